// File: rtl/gemv_axil_csr_bank_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gemv_csr_pkg : register map, bit positions and AXI response codes     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package gemv_csr_pkg;

    localparam int CSR_CTRL   = 0;
    localparam int CSR_STATUS = 1;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;
    localparam int STAT_ERR_BIT    = 2;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_t;

    typedef enum logic [2:0] {
        WR_IDLE    = 3'd0,
        WR_HAVE_AW = 3'd1,
        WR_HAVE_W  = 3'd2,
        WR_COMMIT  = 3'd3,
        WR_RESP    = 3'd4
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/gemv_axil_csr_bank_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gemv_axil_csr_bank_if : AXI4-Lite bundle with master/slave views      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface gemv_axil_csr_bank_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface
`default_nettype wire

// File: rtl/gemv_axil_csr_bank_wr_join.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gemv_axil_wr_join : AW/W holding registers and B-channel sequencer    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module gemv_axil_wr_join
    import gemv_csr_pkg::*;
#(
    parameter int IDX_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                    clk_i,
    input  wire logic                    rst_i,
    input  wire logic [IDX_WIDTH-1:0]    awaddr_i,
    input  wire logic                    awvalid_i,
    output logic                         awready_o,
    input  wire logic [DATA_WIDTH-1:0]   wdata_i,
    input  wire logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  wire logic                    wvalid_i,
    output logic                         wready_o,
    output axi_resp_t                    bresp_o,
    output logic                         bvalid_o,
    input  wire logic                    bready_i,
    input  wire logic                    miss_i,
    output logic                         commit_o,
    output logic [IDX_WIDTH-1:0]         addr_o,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic [DATA_WIDTH/8-1:0]      strb_o
);

    wr_state_t                 state_q;
    logic                      awready_q;
    logic                      wready_q;
    logic                      bvalid_q;
    axi_resp_t                 bresp_q;
    logic [IDX_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH/8-1:0]   strb_q;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_have_aw;
    logic w_have_w;

    assign w_aw_hs   = awvalid_i & awready_q;
    assign w_w_hs    = wvalid_i & wready_q;
    assign w_have_aw = (state_q == WR_HAVE_AW) | w_aw_hs;
    assign w_have_w  = (state_q == WR_HAVE_W)  | w_w_hs;

    // Readies stay low through reset and come up one cycle after release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= WR_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            if (w_aw_hs) begin
                addr_q <= awaddr_i;
            end
            if (w_w_hs) begin
                data_q <= wdata_i;
                strb_q <= wstrb_i;
            end
            case (state_q)
                WR_IDLE, WR_HAVE_AW, WR_HAVE_W: begin
                    if (w_have_aw && w_have_w) begin
                        state_q   <= WR_COMMIT;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                    end else if (w_have_aw) begin
                        state_q   <= WR_HAVE_AW;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                    end else if (w_have_w) begin
                        state_q   <= WR_HAVE_W;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b0;
                    end else begin
                        state_q   <= WR_IDLE;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                WR_COMMIT: begin
                    state_q  <= WR_RESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= miss_i ? RESP_SLVERR : RESP_OKAY;
                end
                WR_RESP: begin
                    if (bready_i) begin
                        state_q   <= WR_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: state_q <= WR_IDLE;
            endcase
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign commit_o  = (state_q == WR_COMMIT);
    assign addr_o    = addr_q;
    assign data_o    = data_q;
    assign strb_o    = strb_q;

endmodule
`default_nettype wire

// File: rtl/gemv_axil_csr_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gemv_axil_csr_bank : AXI4-Lite CSR bank with START/W1C/IRQ support    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module gemv_axil_csr_bank
    import gemv_csr_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                  ACLK,
    input  wire logic                  ARESET,
    gemv_axil_csr_bank_if.slave        s_axi,
    input  wire logic                  core_busy,
    input  wire logic                  core_done,
    output logic                       start_pulse,
    output logic [NUM_REGS*32-1:0]     cfg_regs,
    output logic                       irq
);

    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    generate
        if (DATA_WIDTH != 32 || NUM_REGS < 4 || NUM_REGS > 256 || ADDR_WIDTH < SW + 2) begin : g_param_check
            $error("gemv_axil_csr_bank: unsupported parameter combination");
        end
    endgenerate

    logic [IW-1:0]  w_wr_idx;
    logic [IW-1:0]  w_rd_idx;
    logic [SW-1:0]  w_wr_sel;
    logic [SW-1:0]  w_rd_sel;
    logic           w_wr_miss;
    logic           w_rd_miss;
    logic           w_commit;
    logic [31:0]    w_wr_data;
    logic [3:0]     w_wr_strb;
    axi_resp_t      w_bresp;
    logic           w_clr_done;
    logic           w_clr_err;
    logic           w_set_err;

    logic [31:0]    regs_q [NUM_REGS];
    logic [31:0]    regs_d [NUM_REGS];
    logic [31:0]    w_img  [NUM_REGS];
    logic           start_q;
    logic           start_d;
    logic           irq_q;
    logic           arready_q;
    logic           rvalid_q;
    logic [31:0]    rdata_q;
    axi_resp_t      rresp_q;

    gemv_axil_wr_join #(
        .IDX_WIDTH  (IW),
        .DATA_WIDTH (32)
    ) u_wr_join (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .awaddr_i  (s_axi.AWADDR[ADDR_WIDTH-1:2]),
        .awvalid_i (s_axi.AWVALID),
        .awready_o (s_axi.AWREADY),
        .wdata_i   (s_axi.WDATA),
        .wstrb_i   (s_axi.WSTRB),
        .wvalid_i  (s_axi.WVALID),
        .wready_o  (s_axi.WREADY),
        .bresp_o   (w_bresp),
        .bvalid_o  (s_axi.BVALID),
        .bready_i  (s_axi.BREADY),
        .miss_i    (w_wr_miss),
        .commit_o  (w_commit),
        .addr_o    (w_wr_idx),
        .data_o    (w_wr_data),
        .strb_o    (w_wr_strb)
    );

    assign s_axi.BRESP = w_bresp;
    assign w_rd_idx    = s_axi.ARADDR[ADDR_WIDTH-1:2];
    assign w_wr_miss   = 32'(w_wr_idx) >= 32'(NUM_REGS);
    assign w_rd_miss   = 32'(w_rd_idx) >= 32'(NUM_REGS);
    assign w_wr_sel    = w_wr_idx[SW-1:0];
    assign w_rd_sel    = w_rd_idx[SW-1:0];

    // CTRL keeps only IRQ_EN and STATUS only DONE/ERR; all other bits of those words stay zero.
    always_comb begin
        regs_d     = regs_q;
        start_d    = 1'b0;
        w_clr_done = 1'b0;
        w_clr_err  = 1'b0;
        w_set_err  = 1'b0;
        if (w_commit && !w_wr_miss) begin
            if (32'(w_wr_idx) == CSR_CTRL) begin
                if (w_wr_strb[0]) begin
                    regs_d[CSR_CTRL][CTRL_IRQ_EN_BIT] = w_wr_data[CTRL_IRQ_EN_BIT];
                    if (w_wr_data[CTRL_START_BIT]) begin
                        w_set_err = core_busy;
                        start_d   = ~core_busy;
                    end
                end
            end else if (32'(w_wr_idx) == CSR_STATUS) begin
                if (w_wr_strb[0]) begin
                    w_clr_done = w_wr_data[STAT_DONE_BIT];
                    w_clr_err  = w_wr_data[STAT_ERR_BIT];
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (w_wr_strb[b]) begin
                        regs_d[w_wr_sel][8*b +: 8] = w_wr_data[8*b +: 8];
                    end
                end
            end
        end
        regs_d[CSR_STATUS][STAT_DONE_BIT] = (regs_q[CSR_STATUS][STAT_DONE_BIT] & ~w_clr_done) | core_done;
        regs_d[CSR_STATUS][STAT_ERR_BIT]  = (regs_q[CSR_STATUS][STAT_ERR_BIT]  & ~w_clr_err)  | w_set_err;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            start_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            start_q <= start_d;
            irq_q   <= regs_q[CSR_CTRL][CTRL_IRQ_EN_BIT] &
                       (regs_q[CSR_STATUS][STAT_DONE_BIT] | regs_q[CSR_STATUS][STAT_ERR_BIT]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            w_img[k] = regs_q[k];
        end
        w_img[CSR_STATUS][STAT_BUSY_BIT] = core_busy;
    end

    // Reads sample the pre-commit image, so a same-cycle write to the same word is not visible.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else if (s_axi.ARVALID && arready_q) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= w_rd_miss ? 32'd0 : w_img[w_rd_sel];
            rresp_q   <= w_rd_miss ? RESP_SLVERR : RESP_OKAY;
        end else if (rvalid_q) begin
            if (s_axi.RREADY) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end
        end else begin
            arready_q <= 1'b1;
        end
    end

    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign start_pulse   = start_q;
    assign irq           = irq_q;

    generate
        for (genvar k = 0; k < NUM_REGS; k++) begin : g_cfg
            assign cfg_regs[32*k +: 32] = w_img[k];
        end
    endgenerate

endmodule
`default_nettype wire
